// File: rtl/resp_pkg.sv
// -----------------------------------------------------------------------------
// resp_pkg
//
// Shared definitions for the output-response capture stage that sits behind
// the mapped 8-output combinational netlist.
//
// Contents:
//   RESP_W, SIG_W, CNT_W : response, signature and pattern-count widths
//   MISR_POLY            : Galois feedback polynomial x^16+x^12+x^5+1
//   MISR_SEED            : signature value loaded at run start and at reset
//   state_e              : capture FSM states
//   misr_step()          : one MISR update folding one response vector
//
// Response bit order is {n77,n68,n65,n56,n48,n42,n9,n6}, with n6 at bit 0.
// -----------------------------------------------------------------------------
package resp_pkg;

    localparam int RESP_W = 8;
    localparam int SIG_W  = 16;
    localparam int CNT_W  = 16;

    localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;
    localparam logic [SIG_W-1:0] MISR_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Shift left by one, apply polynomial feedback when the bit shifted out
    // is set, then inject the response into the low byte.
    function automatic logic [SIG_W-1:0] misr_step(
        input logic [SIG_W-1:0]  cur,
        input logic [RESP_W-1:0] data
    );
        logic [SIG_W-1:0] shifted;
        logic [SIG_W-1:0] feedback;
        logic [SIG_W-1:0] inject;
        shifted  = {cur[SIG_W-2:0], 1'b0};
        feedback = cur[SIG_W-1] ? MISR_POLY : '0;
        inject   = {{(SIG_W-RESP_W){1'b0}}, data};
        return shifted ^ feedback ^ inject;
    endfunction

endpackage

// File: rtl/misr16.sv
// -----------------------------------------------------------------------------
// misr16
//
// Registered 16-bit multiple-input signature register. Folds one response
// vector per enabled cycle using resp_pkg::misr_step.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset, loads MISR_SEED
//   load_seed_i  load MISR_SEED at the next edge (wins over step_en_i)
//   step_en_i    fold data_i into the signature at the next edge
//   data_i       response vector to fold
//   sig_o        current signature (register output)
// -----------------------------------------------------------------------------
module misr16
    import resp_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_seed_i,
    input  logic              step_en_i,
    input  logic [RESP_W-1:0] data_i,
    output logic [SIG_W-1:0]  sig_o
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load_seed_i) begin
            sig_d = MISR_SEED;
        end else if (step_en_i) begin
            sig_d = misr_step(sig_q, data_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q <= MISR_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/resp_misr_capture.sv
// -----------------------------------------------------------------------------
// resp_misr_capture
//
// Captures valid 8-bit response vectors through a one-stage register, folds
// a programmed number of them into a 16-bit MISR, and presents the final
// signature plus a golden-compare flag over a valid/ready handshake.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (overrides everything)
//   start      begin a run; only looked at in IDLE
//   pat_count  number of responses to compact, latched on start
//   exp_sig    golden signature, latched on start
//   res_valid  upstream response valid
//   res_data   response vector {n77,n68,n65,n56,n48,n42,n9,n6}
//   res_ready  stage accepts a response this cycle
//   sig_valid  final signature available
//   sig_data   signature (reads MISR_SEED out of reset)
//   sig_match  sig_data equals latched exp_sig, qualified by sig_valid
//   sig_ready  consumer takes the signature
//   busy       FSM is not in IDLE
//   pat_seen   responses accepted in the current run
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. res_ready and sig_valid depend only on registered state, never
// on res_valid/sig_ready, and sig_valid/sig_data hold until sig_ready.
//
// Pipeline: a response accepted at edge T sits in cap_q and is folded at
// edge T+1. The fold of the final response is also the edge that enters
// DONE, so sig_valid rises together with the final signature.
// -----------------------------------------------------------------------------
module resp_misr_capture
    import resp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  pat_count,
    input  logic [SIG_W-1:0]  exp_sig,
    input  logic              res_valid,
    input  logic [RESP_W-1:0] res_data,
    output logic              res_ready,
    output logic              sig_valid,
    output logic [SIG_W-1:0]  sig_data,
    output logic              sig_match,
    input  logic              sig_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  pat_seen
);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [SIG_W-1:0]  exp_q;
    logic [SIG_W-1:0]  exp_d;
    logic [CNT_W-1:0]  seen_q;
    logic [CNT_W-1:0]  seen_d;
    logic [RESP_W-1:0] cap_q;
    logic [RESP_W-1:0] cap_d;
    logic              cap_vld_q;
    logic              cap_vld_d;

    logic              load_seed;
    logic              room;
    logic              accept;
    logic [SIG_W-1:0]  misr;

    // Comparing against the latched count (instead of counting down or
    // wrapping) makes pat_seen stop exactly at the limit, including 16'hFFFF.
    assign room = (seen_q < cnt_q);

    // Next-state, datapath enables and register next values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        exp_d     = exp_q;
        seen_d    = seen_q;
        cap_d     = cap_q;
        cap_vld_d = 1'b0;
        load_seed = 1'b0;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d     = pat_count;
                    exp_d     = exp_sig;
                    seen_d    = '0;
                    load_seed = 1'b1;
                    // An empty run has nothing to fold: the seed is the answer.
                    state_d   = (pat_count == '0) ? DONE : RUN;
                end
            end

            RUN: begin
                accept = res_valid && room;
                if (accept) begin
                    cap_d     = res_data;
                    cap_vld_d = 1'b1;
                    seen_d    = seen_q + CNT_W'(1);
                end
                // cap_vld_q with seen_q at the limit can only be the last
                // response: no further accepts happen once room drops.
                if (cap_vld_q && (seen_q == cnt_q)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                if (sig_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            exp_q     <= '0;
            seen_q    <= '0;
            cap_q     <= '0;
            cap_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            seen_q    <= seen_d;
            cap_q     <= cap_d;
            cap_vld_q <= cap_vld_d;
        end
    end

    // cap_vld_q is only ever set by an accept in RUN, so it doubles as the
    // fold enable without further state qualification.
    misr16 u_misr (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_seed_i (load_seed),
        .step_en_i   (cap_vld_q),
        .data_i      (cap_q),
        .sig_o       (misr)
    );

    // Outputs decode registered state only; res_data never reaches them
    // without passing through cap_q and the MISR register.
    assign res_ready = (state_q == RUN) && room;
    assign sig_valid = (state_q == DONE);
    assign sig_data  = misr;
    assign sig_match = (state_q == DONE) && (misr == exp_q);
    assign busy      = (state_q != IDLE);
    assign pat_seen  = seen_q;

endmodule

// File: tb/tb_resp_misr_capture.sv
// -----------------------------------------------------------------------------
// tb_resp_misr_capture
//
// Self-checking bench for resp_misr_capture. The reference signature treats
// the MISR as polynomial arithmetic over GF(2): multiply the running value by
// x, reduce modulo x^16+x^12+x^5+1, then add the response byte.
// -----------------------------------------------------------------------------
module tb_resp_misr_capture;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] pat_count;
    logic [15:0] exp_sig;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_ready;
    logic        sig_valid;
    logic [15:0] sig_data;
    logic        sig_match;
    logic        sig_ready;
    logic        busy;
    logic [15:0] pat_seen;

    always #5 clk = ~clk;

    resp_misr_capture dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pat_count (pat_count),
        .exp_sig   (exp_sig),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .sig_valid (sig_valid),
        .sig_data  (sig_data),
        .sig_match (sig_match),
        .sig_ready (sig_ready),
        .busy      (busy),
        .pat_seen  (pat_seen)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]  stim_q[$];   // responses offered in the current run
    logic [15:0] exp_q[$];    // scoreboard of expected signatures

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_sig(input int n);
        logic [16:0] r;
        r = 17'h0FFFF;
        for (int i = 0; i < n; i++) begin
            r = r << 1;                       // multiply by x
            if (r[16]) r = r ^ 17'h11021;     // reduce mod the polynomial
            r = r ^ {9'd0, stim_q[i]};        // add the response
        end
        return r[15:0];
    endfunction

    // ---------------- driver tasks ----------------
    // Start a run and offer stim_q (with random gaps) until sig_valid or the
    // edge budget runs out. lat = edges from last accept (or start) to DONE.
    task automatic do_run(input logic [15:0] cnt, input logic [15:0] golden,
                          input int gap_pct, output int accepts, output int lat,
                          output int done_edge, output bit ready_seen,
                          output bit timed_out);
        int idx;
        int e;
        int last_acc;
        idx = 0; e = 0; timed_out = 1'b0; ready_seen = 1'b0;
        start = 1'b1; pat_count = cnt; exp_sig = golden;
        @(posedge clk); #1;
        e = 1; last_acc = 1;
        start = 1'b0;
        while (!sig_valid) begin
            if (e > 600) begin
                timed_out = 1'b1;
                break;
            end
            if ((idx < stim_q.size()) && ($urandom_range(99) >= gap_pct)) begin
                res_valid = 1'b1;
                res_data  = stim_q[idx];
            end else begin
                res_valid = 1'b0;
                res_data  = 8'($urandom);
            end
            if (res_ready) ready_seen = 1'b1;
            if (res_valid && res_ready) begin
                idx++;
                last_acc = e + 1;
            end
            @(posedge clk); #1;
            e++;
        end
        res_valid = 1'b0;
        accepts   = idx;
        lat       = e - last_acc;
        done_edge = e;
    endtask

    task automatic release_sig();
        sig_ready = 1'b1;
        @(posedge clk); #1;
        sig_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b1; pat_count = 16'd3; exp_sig = 16'h1234;
        res_valid = 1'b1; res_data = 8'h5A; sig_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; res_valid = 1'b0; sig_ready = 1'b0;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests_run++; if (sig_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_sig_valid got=%b exp=0", sig_valid); end
        tests_run++; if (res_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_res_ready got=%b exp=0", res_ready); end
        tests_run++; if (sig_match !== 1'b0) begin tests_failed++; $display("FAIL reset_sig_match got=%b exp=0", sig_match); end
        tests_run++; if (sig_data !== 16'hFFFF) begin tests_failed++; $display("FAIL reset_sig_data got=%h exp=ffff", sig_data); end
        tests_run++; if (pat_seen !== 16'd0) begin tests_failed++; $display("FAIL reset_pat_seen got=%0d exp=0", pat_seen); end
        // IDLE must not accept responses even if offered.
        res_valid = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0;
        tests_run++; if (pat_seen !== 16'd0 || busy !== 1'b0) begin tests_failed++; $display("FAIL idle_ignores_res got_seen=%0d got_busy=%b exp=0/0", pat_seen, busy); end
    endtask

    task automatic test_zero_count();
        int acc; int lat; int de; bit rdy; bit to;
        stim_q = {};
        do_run(16'd0, 16'hFFFF, 0, acc, lat, de, rdy, to);
        tests_run++; if (to) begin tests_failed++; $display("FAIL zero_timeout got=timeout exp=done"); end
        tests_run++; if (lat !== 0) begin tests_failed++; $display("FAIL zero_latency got=%0d exp=0", lat); end
        tests_run++; if (sig_data !== 16'hFFFF) begin tests_failed++; $display("FAIL zero_sig got=%h exp=ffff", sig_data); end
        tests_run++; if (sig_match !== 1'b1) begin tests_failed++; $display("FAIL zero_match got=%b exp=1", sig_match); end
        tests_run++; if (rdy || res_ready !== 1'b0) begin tests_failed++; $display("FAIL zero_res_ready got=%b exp=0", rdy | res_ready); end
        release_sig();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL zero_release got_busy=%b exp=0", busy); end
    endtask

    task automatic test_single_zero();
        int acc; int lat; int de; bit rdy; bit to;
        stim_q = {8'h00};
        do_run(16'd1, 16'h0000, 0, acc, lat, de, rdy, to);
        tests_run++; if (to || lat !== 1) begin tests_failed++; $display("FAIL single0_latency got=%0d timeout=%b exp=1", lat, to); end
        tests_run++; if (sig_data !== 16'hEFDF) begin tests_failed++; $display("FAIL single0_sig got=%h exp=efdf", sig_data); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests_run++; if (sig_valid !== 1'b1 || sig_data !== 16'hEFDF) begin tests_failed++; $display("FAIL single0_hold got_valid=%b got_sig=%h exp=1/efdf", sig_valid, sig_data); end
        end
        release_sig();
        tests_run++; if (busy !== 1'b0 || sig_valid !== 1'b0) begin tests_failed++; $display("FAIL single0_release got_busy=%b got_valid=%b exp=0/0", busy, sig_valid); end
    endtask

    task automatic test_single_a5();
        int acc; int lat; int de; bit rdy; bit to;
        stim_q = {8'hA5};
        do_run(16'd1, 16'hEF7A, 0, acc, lat, de, rdy, to);
        tests_run++; if (to || sig_data !== 16'hEF7A) begin tests_failed++; $display("FAIL a5_sig got=%h exp=ef7a", sig_data); end
        tests_run++; if (sig_match !== 1'b1) begin tests_failed++; $display("FAIL a5_match got=%b exp=1", sig_match); end
        release_sig();
        do_run(16'd1, 16'h0000, 0, acc, lat, de, rdy, to);
        tests_run++; if (to || sig_data !== 16'hEF7A) begin tests_failed++; $display("FAIL a5_rerun_sig got=%h exp=ef7a", sig_data); end
        tests_run++; if (sig_match !== 1'b0) begin tests_failed++; $display("FAIL a5_rerun_match got=%b exp=0", sig_match); end
        release_sig();
    endtask

    task automatic test_back_to_back();
        int acc; int lat; int de; bit rdy; bit to;
        logic [15:0] held;
        // Three responses offered, only two requested: the third must be refused.
        stim_q = {8'h00, 8'h00, 8'h00};
        do_run(16'd2, 16'hCF9F, 0, acc, lat, de, rdy, to);
        tests_run++; if (to || acc !== 2) begin tests_failed++; $display("FAIL b2b_accepts got=%0d exp=2", acc); end
        // start edge 1, accepts at edges 2 and 3, final fold at edge 4.
        tests_run++; if (de !== 4 || lat !== 1) begin tests_failed++; $display("FAIL b2b_timing got_edge=%0d got_lat=%0d exp=4/1", de, lat); end
        tests_run++; if (sig_data !== 16'hCF9F) begin tests_failed++; $display("FAIL b2b_sig got=%h exp=cf9f", sig_data); end
        tests_run++; if (pat_seen !== 16'd2) begin tests_failed++; $display("FAIL b2b_pat_seen got=%0d exp=2", pat_seen); end
        held = sig_data;
        res_valid = 1'b1; res_data = 8'h3C;
        for (int i = 0; i < 2; i++) begin
            tests_run++; if (res_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_extra_ready got=%b exp=0", res_ready); end
            @(posedge clk); #1;
        end
        res_valid = 1'b0;
        tests_run++; if (pat_seen !== 16'd2 || sig_data !== held) begin tests_failed++; $display("FAIL b2b_extra_ignored got_seen=%0d got_sig=%h exp=2/%h", pat_seen, sig_data, held); end
        release_sig();
    endtask

    task automatic test_stall();
        int acc; int lat; int de; bit rdy; bit to;
        logic [15:0] ref_sig;
        logic [15:0] golden;
        stim_q = {};
        for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom));
        ref_sig = model_sig(4);
        golden  = ref_sig;
        do_run(16'd4, golden, 30, acc, lat, de, rdy, to);
        tests_run++; if (to || sig_data !== ref_sig || sig_match !== 1'b1) begin tests_failed++; $display("FAIL stall_sig got=%h match=%b exp=%h/1", sig_data, sig_match, ref_sig); end
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; pat_count = 16'($urandom); exp_sig = 16'($urandom);
            @(posedge clk); #1;
            tests_run++; if (sig_valid !== 1'b1 || sig_data !== ref_sig || pat_seen !== 16'd4) begin tests_failed++; $display("FAIL stall_hold got_valid=%b got_sig=%h got_seen=%0d exp=1/%h/4", sig_valid, sig_data, pat_seen, ref_sig); end
        end
        // start together with sig_ready: the handshake wins, no new run.
        start = 1'b1; sig_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; sig_ready = 1'b0;
        tests_run++; if (busy !== 1'b0 || sig_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_release got_busy=%b got_valid=%b exp=0/0", busy, sig_valid); end
        @(posedge clk); #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL stall_no_restart got_busy=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_run();
        int acc; int lat; int de; bit rdy; bit to;
        logic [15:0] ref_sig;
        stim_q = {};
        for (int i = 0; i < 3; i++) stim_q.push_back(8'($urandom));
        ref_sig = model_sig(3);
        start = 1'b1; pat_count = 16'd3; exp_sig = ref_sig;
        @(posedge clk); #1;
        start = 1'b0;
        res_valid = 1'b1; res_data = stim_q[0];
        tests_run++; if (res_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_ready got=%b exp=1", res_ready); end
        @(posedge clk); #1;
        tests_run++; if (pat_seen !== 16'd1) begin tests_failed++; $display("FAIL midrst_seen1 got=%0d exp=1", pat_seen); end
        res_data = stim_q[1]; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; res_valid = 1'b0;
        tests_run++; if (busy !== 1'b0 || pat_seen !== 16'd0 || sig_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_clear got_busy=%b got_seen=%0d got_valid=%b exp=0/0/0", busy, pat_seen, sig_valid); end
        tests_run++; if (sig_data !== 16'hFFFF || res_ready !== 1'b0) begin tests_failed++; $display("FAIL midrst_seed got_sig=%h got_ready=%b exp=ffff/0", sig_data, res_ready); end
        do_run(16'd3, ref_sig, 20, acc, lat, de, rdy, to);
        tests_run++; if (to || sig_data !== ref_sig || sig_match !== 1'b1) begin tests_failed++; $display("FAIL midrst_rerun got=%h match=%b exp=%h/1", sig_data, sig_match, ref_sig); end
        release_sig();
    endtask

    task automatic test_big_count();
        start = 1'b1; pat_count = 16'hFFFF; exp_sig = 16'h0;
        @(posedge clk); #1;
        start = 1'b0;
        res_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            res_data = 8'($urandom);
            @(posedge clk); #1;
        end
        res_valid = 1'b0;
        tests_run++; if (pat_seen !== 16'd6 || res_ready !== 1'b1) begin tests_failed++; $display("FAIL big_progress got_seen=%0d got_ready=%b exp=6/1", pat_seen, res_ready); end
        tests_run++; if (busy !== 1'b1 || sig_valid !== 1'b0) begin tests_failed++; $display("FAIL big_state got_busy=%b got_valid=%b exp=1/0", busy, sig_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        int acc; int lat; int de; bit rdy; bit to;
        int n;
        logic [15:0] ref_sig;
        logic [15:0] golden;
        logic [15:0] want;
        for (int run = 0; run < 20; run++) begin
            n = $urandom_range(10, 1);
            stim_q = {};
            for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
            ref_sig = model_sig(n);
            golden  = ($urandom_range(1) == 1) ? ref_sig : 16'($urandom);
            exp_q.push_back(ref_sig);
            do_run(16'(n), golden, $urandom_range(60), acc, lat, de, rdy, to);
            want = exp_q.pop_front();
            tests_run++; if (to || sig_data !== want) begin tests_failed++; $display("FAIL rand_sig run=%0d got=%h exp=%h", run, sig_data, want); end
            tests_run++; if (sig_match !== (want == golden)) begin tests_failed++; $display("FAIL rand_match run=%0d got=%b exp=%b", run, sig_match, want == golden); end
            tests_run++; if (pat_seen !== 16'(n) || lat !== 1) begin tests_failed++; $display("FAIL rand_count run=%0d got_seen=%0d got_lat=%0d exp=%0d/1", run, pat_seen, lat, n); end
            repeat ($urandom_range(3)) @(posedge clk);
            #1;
            release_sig();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1; start = 1'b0; pat_count = '0; exp_sig = '0;
        res_valid = 1'b0; res_data = '0; sig_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_zero_count();
        test_single_zero();
        test_single_a5();
        test_back_to_back();
        test_stall();
        test_reset_mid_run();
        test_big_count();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=time_limit exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
